clint_irq_ctrl: RTL and testbench

//   Core-local interrupt controller on the data bus, directly upstream of the core's trint/swint/exint inputs.

---
 rtl/clint_irq_ctrl_if.sv | 26 ++
 rtl/clint_irq_ctrl.sv | 154 +++++++++++++++
 tb/tb_clint_irq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/clint_irq_ctrl_if.sv
// Data-bus request/response types and the slave-port interface for the CLINT.
// The master side drives dreq; the CLINT answers on dresp.
package clint_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

interface clint_irq_ctrl_if;
    import clint_pkg::*;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/clint_irq_ctrl.sv
// Core-local interrupt controller: mtime/mtimecmp/msip on the data bus, level irqs out.
// Define CLINT_EXT_SYNC_EN to pass ext_irq through a 2-flop synchronizer.
module clint_irq_ctrl
    import clint_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic       clk,
    input  logic       reset,
    clint_irq_ctrl_if.slave dbus,
    input  logic       ext_irq,
    output logic       trint,
    output logic       swint,
    output logic       exint
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {IDLE, RESP} state_e;

    state_e        state_q, state_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          msip_q, msip_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trint_q, trint_d;
    logic          swint_q, swint_d;

    logic        in_win, accept, wr, tick;
    logic        sel_msip, sel_cmp, sel_time;
    logic [12:0] off;
    logic        unused_bits;

    // Window is 64 KiB aligned, so the upper address bits select it.
    assign in_win   = dbus.dreq.addr[63:16] == BASE_ADDR[63:16];
    assign off      = dbus.dreq.addr[15:3];
    assign sel_msip = off == 13'h0000;
    assign sel_cmp  = off == 13'h0800;
    assign sel_time = off == 13'h17FF;
    assign accept   = (state_q == IDLE) && dbus.dreq.valid && in_win;
    assign wr       = accept && (|dbus.dreq.strobe);
    assign tick     = cnt_q == CW'(PRESCALE - 1);

    assign unused_bits = ^{dbus.dreq.size, dbus.dreq.addr[2:0]};

    function automatic logic [63:0] merge(
        input logic [63:0] old_v,
        input logic [63:0] new_v,
        input logic [7:0]  strb
    );
        logic [63:0] r;
        r = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        trint_d    = mtime_q >= mtimecmp_q;
        swint_d    = msip_q;

        unique case (state_q)
            IDLE: if (accept) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            unique case (1'b1)
                sel_msip: rdata_d = {63'd0, msip_q};
                sel_cmp:  rdata_d = mtimecmp_q;
                sel_time: rdata_d = mtime_q;
                default:  rdata_d = 64'd0;
            endcase
        end

        // A bus write to mtime overrides that cycle's tick.
        if (wr) begin
            if (sel_msip && dbus.dreq.strobe[0]) msip_d = dbus.dreq.data[0];
            if (sel_cmp)
                mtimecmp_d = merge(mtimecmp_q, dbus.dreq.data, dbus.dreq.strobe);
            if (sel_time)
                mtime_d = merge(mtime_q, dbus.dreq.data, dbus.dreq.strobe);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            msip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            cnt_q      <= '0;
            trint_q    <= 1'b0;
            swint_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            cnt_q      <= cnt_d;
            trint_q    <= trint_d;
            swint_q    <= swint_d;
        end
    end

    always_comb begin
        dbus.dresp         = '0;
        dbus.dresp.addr_ok = state_q == RESP;
        dbus.dresp.data_ok = state_q == RESP;
        dbus.dresp.data    = (state_q == RESP) ? rdata_q : 64'd0;
    end

`ifdef CLINT_EXT_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], ext_irq};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign exint = sync_q[1];
`else
    logic ext_q, ext_d;

    always_comb begin
        ext_d = ext_irq;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ext_q <= 1'b0;
        else        ext_q <= ext_d;
    end

    assign exint = ext_q;
`endif

    assign trint = trint_q;
    assign swint = swint_q;
endmodule

// File: tb/tb_clint_irq_ctrl.sv
// Directed bench for clint_irq_ctrl: register table plus timer/msip/wrap/reset/ext sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_clint_irq_ctrl;
    import clint_pkg::*;

    localparam logic [63:0] BASE = 64'h0200_0000;
    localparam logic [63:0] A_MSIP = BASE + 64'h0000;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
`ifdef CLINT_EXT_SYNC_EN
    localparam int EXT_LAT = 2;
`else
    localparam int EXT_LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic ext_irq;
    logic trint, swint, exint;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    clint_irq_ctrl_if bus();

    clint_irq_ctrl #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .dbus    (bus),
        .ext_irq (ext_irq),
        .trint   (trint),
        .swint   (swint),
        .exint   (exint)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, output logic [63:0] rd,
                        output int rc);
        @(negedge clk);
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = a;
        bus.dreq.size   = 2'd3;
        bus.dreq.strobe = s;
        bus.dreq.data   = d;
        @(negedge clk);
        bus.dreq.valid  = 1'b0;
        bus.dreq.strobe = 8'h00;
        chk("data_ok", {63'd0, bus.dresp.data_ok}, 64'd1);
        chk("addr_ok", {63'd0, bus.dresp.addr_ok}, 64'd1);
        rd = bus.dresp.data;
        rc = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        int          rc, seen;
        logic        found;

        tbl[0]  = '{A_MSIP, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        tbl[1]  = '{A_MSIP, 8'h00, 64'd0, 64'd1};
        tbl[2]  = '{A_MSIP, 8'hFF, 64'd0, 64'd0};
        tbl[3]  = '{A_MSIP, 8'h00, 64'd0, 64'd0};
        tbl[4]  = '{A_CMP, 8'hFF, 64'h1122, 64'd0};
        tbl[5]  = '{A_CMP, 8'h01, 64'hAB, 64'd0};
        tbl[6]  = '{A_CMP, 8'h00, 64'd0, 64'h11AB};
        tbl[7]  = '{BASE + 64'h8000, 8'hFF, 64'hDEAD, 64'd0};
        tbl[8]  = '{BASE + 64'h8000, 8'h00, 64'd0, 64'd0};
        tbl[9]  = '{A_CMP + 64'd4, 8'h00, 64'd0, 64'h11AB};
        tbl[10] = '{A_CMP, 8'hC0, 64'h5566_7788_9900_AABB, 64'd0};
        tbl[11] = '{A_CMP, 8'h00, 64'd0, 64'h5566_0000_0000_11AB};
        tbl[12] = '{BASE + 64'hBFF0, 8'h00, 64'd0, 64'd0};
        tbl[13] = '{A_CMP, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};

        reset = 1'b0;
        ext_irq = 1'b0;
        bus.dreq = '0;
        repeat (3) @(negedge clk);
        chk("rst_data_ok", {63'd0, bus.dresp.data_ok}, 64'd0);
        chk("rst_trint", {63'd0, trint}, 64'd0);
        chk("rst_swint", {63'd0, swint}, 64'd0);
        chk("rst_exint", {63'd0, exint}, 64'd0);

        // Idle count after release
        reset = 1'b1;
        repeat (10) @(posedge clk);
        xfer(A_TIME, 8'h00, 64'd0, rd, rc);
        chk("mtime_idle10", rd, 64'd10);
        chk("idle_trint", {63'd0, trint}, 64'd0);
        @(negedge clk);
        chk("data_ok_single", {63'd0, bus.dresp.data_ok}, 64'd0);

        // Software interrupt
        xfer(A_MSIP, 8'hFF, 64'd1, rd, rc);
        chk("swint_at_resp", {63'd0, swint}, 64'd0);
        @(negedge clk);
        chk("swint_set", {63'd0, swint}, 64'd1);
        xfer(A_MSIP, 8'h00, 64'd0, rd, rc);
        chk("msip_rd1", rd, 64'd1);
        xfer(A_MSIP, 8'hFF, 64'd0, rd, rc);
        @(negedge clk);
        chk("swint_clr", {63'd0, swint}, 64'd0);
        xfer(A_MSIP, 8'h00, 64'd0, rd, rc);
        chk("msip_rd0", rd, 64'd0);

        // Timer compare at 0x20
        xfer(A_TIME, 8'hFF, 64'd0, rd, rc);
        xfer(A_CMP, 8'hFF, 64'h20, rd, seen);
        chk("trint_before", {63'd0, trint}, 64'd0);
        found = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (trint) begin
                found = 1'b1;
                seen = cyc;
            end
        end
        chk("trint_found", {63'd0, found}, 64'd1);
        chk("trint_rise_cyc", 64'(seen - rc), 64'h21);
        xfer(A_CMP, 8'hFF, 64'hFFFF_FFFF, rd, rc);
        chk("trint_hold_resp", {63'd0, trint}, 64'd1);
        @(negedge clk);
        chk("trint_clr", {63'd0, trint}, 64'd0);

        // 64-bit wrap with mtimecmp = 0
        xfer(A_CMP, 8'hFF, 64'd0, rd, rc);
        xfer(A_TIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, rd, rc);
        chk("wrap_trint0", {63'd0, trint}, 64'd1);
        xfer(A_TIME, 8'h00, 64'd0, rd, rc);
        chk("wrap_rd_max", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_trint1", {63'd0, trint}, 64'd1);
        xfer(A_TIME, 8'h00, 64'd0, rd, rc);
        chk("wrap_rd_1", rd, 64'd1);
        chk("wrap_trint2", {63'd0, trint}, 64'd1);

        // Reset while a response is pending
        xfer(A_MSIP, 8'hFF, 64'd1, rd, rc);
        @(negedge clk);
        bus.dreq.valid = 1'b1;
        bus.dreq.addr  = A_CMP;
        bus.dreq.strobe = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.dreq.valid = 1'b0;
        #1;
        chk("rstmid_data_ok", {63'd0, bus.dresp.data_ok}, 64'd0);
        chk("rstmid_addr_ok", {63'd0, bus.dresp.addr_ok}, 64'd0);
        chk("rstmid_data", bus.dresp.data, 64'd0);
        chk("rstmid_swint", {63'd0, swint}, 64'd0);
        chk("rstmid_trint", {63'd0, trint}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", {63'd0, bus.dresp.data_ok}, 64'd0);
        end

        // External interrupt latency
        ext_irq = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("exint_rise", {63'd0, exint}, {63'd0, k >= EXT_LAT});
        end
        ext_irq = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("exint_fall", {63'd0, exint}, {63'd0, k < EXT_LAT});
        end

        // Register table; reads are compared, writes only check the handshake
        for (int i = 0; i < 14; i++) begin
            xfer(tbl[i].addr, tbl[i].strb, tbl[i].wdata, rd, rc);
            if (tbl[i].strb == 8'h00)
                chk($sformatf("tbl_rd_%0d", i), rd, tbl[i].exp);
        end

        // Out-of-window request gets no response
        @(negedge clk);
        bus.dreq.valid = 1'b1;
        bus.dreq.addr  = BASE + 64'h1_0000;
        @(negedge clk);
        bus.dreq.valid = 1'b0;
        chk("oow_no_resp", {63'd0, bus.dresp.data_ok}, 64'd0);
        @(negedge clk);
        chk("oow_no_resp2", {63'd0, bus.dresp.data_ok}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
